// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and helpers for the audio output path.
//   sample_t  : 16-bit signed PCM sample
//   stereo_t  : packed {left, right} sample pair as carried by the sample bus
//   vol_scale : 3-bit volume attenuation (0 = mute, 7 = full scale)
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int DATA_BITS = 16;
    localparam int SLOT_BITS = 32;
    localparam logic [2:0] VOL_MUTE = 3'd0;

    typedef logic signed [DATA_BITS-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    // Each volume step below full scale halves the amplitude; the arithmetic
    // shift keeps the sign so negative samples stay negative.
    function automatic sample_t vol_scale(sample_t s, logic [2:0] vol);
        logic [2:0] shift;
        shift = 3'd7 - vol;
        if (vol == VOL_MUTE) begin
            return '0;
        end
        return s >>> shift;
    endfunction

endpackage

// File: rtl/sample_fifo2.sv
// -----------------------------------------------------------------------------
// sample_fifo2
// Two-entry valid/ready FIFO of stereo sample pairs.
//   clk, reset : system clock, asynchronous active-high reset
//   push_i     : producer offers data_i (accepted only while ready_o = 1)
//   data_i     : stereo pair to store
//   ready_o    : registered "room available" flag
//   pop_i      : consumer removes the head entry (ignored when empty)
//   empty_o    : no stored entries
//   head_o     : oldest stored entry
// No bypass path: a push is never visible at head_o in the same cycle.
// -----------------------------------------------------------------------------
module sample_fifo2
    import audio_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  stereo_t data_i,
    output logic    ready_o,
    input  logic    pop_i,
    output logic    empty_o,
    output stereo_t head_o
);

    stereo_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       ready_q;
    logic       do_push;
    logic       do_pop;

    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && (count_q != 2'd0);

    // Occupancy bookkeeping; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // ready is registered from the next occupancy, so a full buffer that is
    // popped this cycle still refuses a push until the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            ready_q <= (count_d < 2'd2);
        end
    end

    assign ready_o = ready_q;
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/i2s_audio_tx.sv
// -----------------------------------------------------------------------------
// i2s_audio_tx
// Stereo I2S transmitter for a Pmod I2S2 class DAC. Buffers sample pairs from
// the track mixer, applies volume at each frame start and serialises them with
// MCLK/SCK/LRCK derived from the 100 MHz system clock.
//   clk, reset        : system clock, asynchronous active-high reset
//   in_valid/in_ready : sample pair handshake (2-deep buffer)
//   audio_left/right  : signed 16-bit samples
//   volume            : 0 = mute .. 7 = full scale, sampled at frame latch
//   mclk, sck, lrck   : DAC clocks (lrck 0 = left slot, 1 = right slot)
//   sdout             : serial data, MSB first, zero padded to 32-bit slots
//   frame_tick        : one-cycle pulse on the frame latch cycle
//   underrun          : sticky, a frame started with the buffer empty
// Build option: define I2S_DELAY_EN for standard I2S (MSB one SCK after the
// lrck edge); left-justified format otherwise.
// LRCK_BIT must be SCK_BIT + 6 so each channel slot is 32 SCK periods.
// -----------------------------------------------------------------------------
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int MCLK_BIT = 1,
    parameter int SCK_BIT  = 3,
    parameter int LRCK_BIT = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    input  logic [2:0]  volume,
    output logic        mclk,
    output logic        sck,
    output logic        lrck,
    output logic        sdout,
    output logic        frame_tick,
    output logic        underrun
);

    localparam int POS_W = $clog2(SLOT_BITS);

    logic [LRCK_BIT:0] div_q;
    logic [LRCK_BIT:0] div_d;
    logic              latch;
    logic              fifo_empty;
    stereo_t           fifo_head;
    stereo_t           fifo_in;
    sample_t           cur_l_q;
    sample_t           cur_l_d;
    sample_t           cur_r_q;
    sample_t           cur_r_d;
    logic              underrun_q;
    logic              underrun_d;
    logic              mclk_q;
    logic              sck_q;
    logic              lrck_q;
    logic              sdout_q;
    logic              sdout_d;
    logic              frame_tick_q;
    logic [POS_W-1:0]  bitpos;
    sample_t           slot_sample;
`ifdef I2S_DELAY_EN
    logic [POS_W-1:0]  bit_idx;
`endif

    assign div_d   = div_q + 1'b1;
    assign latch   = &div_q;
    assign fifo_in = {audio_left, audio_right};

    sample_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .data_i  (fifo_in),
        .ready_o (in_ready),
        .pop_i   (latch),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Frame latch: load the next scaled pair, or keep replaying the current
    // one and flag the underrun when the mixer has fallen behind.
    always_comb begin
        cur_l_d    = cur_l_q;
        cur_r_d    = cur_r_q;
        underrun_d = underrun_q;
        if (latch) begin
            if (!fifo_empty) begin
                cur_l_d = vol_scale(fifo_head.left, volume);
                cur_r_d = vol_scale(fifo_head.right, volume);
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    // Serial bit for the next div_cnt value. bitpos only changes when the
    // low SCK_BIT+1 counter bits roll over, which is exactly when sck falls,
    // so sdout is stable for the whole high phase of sck.
    always_comb begin
        bitpos      = div_d[LRCK_BIT-1:SCK_BIT+1];
        slot_sample = div_d[LRCK_BIT] ? cur_r_d : cur_l_d;
        sdout_d     = 1'b0;
`ifdef I2S_DELAY_EN
        bit_idx = 5'd16 - bitpos;
        if ((bitpos != 5'd0) && (bitpos <= 5'd16)) begin
            sdout_d = slot_sample[bit_idx[3:0]];
        end
`else
        if (!bitpos[4]) begin
            sdout_d = slot_sample[4'd15 - bitpos[3:0]];
        end
`endif
    end

    // All pin outputs are registered from the next counter value so they are
    // glitch-free and mutually aligned with div_cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q        <= '0;
            mclk_q       <= 1'b0;
            sck_q        <= 1'b0;
            lrck_q       <= 1'b0;
            sdout_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            underrun_q   <= 1'b0;
            cur_l_q      <= '0;
            cur_r_q      <= '0;
        end else begin
            div_q        <= div_d;
            mclk_q       <= div_d[MCLK_BIT];
            sck_q        <= div_d[SCK_BIT];
            lrck_q       <= div_d[LRCK_BIT];
            sdout_q      <= sdout_d;
            frame_tick_q <= &div_d;
            underrun_q   <= underrun_d;
            cur_l_q      <= cur_l_d;
            cur_r_q      <= cur_r_d;
        end
    end

    assign mclk       = mclk_q;
    assign sck        = sck_q;
    assign lrck       = lrck_q;
    assign sdout      = sdout_q;
    assign frame_tick = frame_tick_q;
    assign underrun   = underrun_q;

endmodule
